text_msg_scheduler: RTL and testbench
=====================================

Name: text_msg_scheduler

Overview:
Shares a single on-screen message text slot between several game-logic requesters, such as the game FSM, level controller and score logic. Examples of messages are "READY!", "GAME OVER" and "PAUSED".
- Arbitrates requests by fixed priority.
- Times each message in frames and optionally blinks it.
- Changes the displayed message id and visibility only on frame boundaries, so the text renderer never tears mid-frame.
- Its msg_id/msg_visible outputs drive the message-select mux and enable of the text layer.

Parameters:
NUM_REQ, 4, number of requesters; index 0 has the highest priority.
MSG_ID_W, 3, width of the message identifier.
FRAME_CNT_W, 8, width of the duration counter, in frames.
BLINK_FRAMES, 16, number of frames per blink half-period; must be at least 1.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at the start of vertical blank
req  in  NUM_REQ  level request per requester
req_msg_id  in  NUM_REQ*MSG_ID_W  message id per requester; requester i uses slice [i*MSG_ID_W +: MSG_ID_W]
req_frames  in  NUM_REQ*FRAME_CNT_W  display duration per requester; 0 means persistent until cancel or preempt
req_blink  in  NUM_REQ  blink enable per requester
cancel  in  NUM_REQ  level; ends the message if asserted by the current owner
grant  out  NUM_REQ  one-cycle one-hot pulse on acceptance
done  out  NUM_REQ  one-cycle one-hot pulse when the owner's message ends
msg_id  out  MSG_ID_W  message currently selected for display
msg_visible  out  1  enable for the text layer
busy  out  1  high in every state except IDLE
owner  out  $clog2(NUM_REQ)  index of the current owner

Behaviour:
- Reset is asynchronous and active-low; clock is clk. All outputs reset to 0 and the FSM resets to IDLE, including when reset is asserted mid-message. All outputs are registered.
- States are IDLE, ARM, SHOW and DONE.
- IDLE:
  - If any req bit is set, select the lowest set index j.
  - Next cycle: grant[j]=1 for exactly one cycle, owner=j, and latch id, frames and blink for j; state becomes ARM.
  - The requester must drop req after seeing grant. A req still high when the FSM returns to IDLE is granted again.
- ARM:
  - Waits for frame_start; does not sample req.
  - On frame_start: msg_id=latched id, msg_visible=1, frames_left=latched frames, blink_cnt=0, phase=visible; state becomes SHOW.
- SHOW: evaluated only on frame_start cycles, with priority in this order:
  1. cancel[owner]=1: msg_visible=0, state becomes DONE.
  2. Any req[k] with k<owner (preempt): msg_visible=0, state becomes DONE.
  3. Latched frames≠0 and frames_left==1 (expiry): msg_visible=0, state becomes DONE.
  4. Otherwise:
     - If latched frames≠0, decrement frames_left.
     - If blink is enabled: blink_cnt increments; on reaching BLINK_FRAMES-1 it wraps to 0 and phase toggles; msg_visible=phase.
- SHOW without frame_start: cancel or req do not act; msg_visible and msg_id are held.
- Cancel between frame_start pulses is not latched; it must be held until the next frame_start.
- Message lifetime:
  - A message with latched frames=N≥1 is visible for exactly N frame_start intervals. Visibility goes low on the N-th frame_start after the ARM→SHOW edge.
  - frames=0 with blink: blinks indefinitely.
- DONE: done[owner]=1 for one cycle, then state becomes IDLE. msg_id is held (not cleared). busy drops when IDLE is entered.
- Simultaneous events:
  - Cancel, preempt and expiry in the same frame_start produce a single DONE and a single done pulse.
  - A preempting requester is granted from IDLE on the cycle after DONE, then waits for the next frame_start in ARM. This yields one blank frame between messages, which is required.
- cancel from a non-owner is ignored. req bits with index greater than owner are ignored during SHOW.
- Arithmetic: frames_left is FRAME_CNT_W bits unsigned and never wraps, because it is never decremented at 1. blink_cnt is $clog2(BLINK_FRAMES)+1 bits.

Test Plan:
- Reset, then req[2]=1 with id 5, frames 3, blink 0. Required: grant=0100 the cycle after req. At the 1st frame_start: msg_id=5, msg_visible=1. msg_visible=0 at the 3rd following frame_start, done=0100 one cycle later, busy=0 after that.
- req[1] with frames 0, blink 1, BLINK_FRAMES=2. Required: visibility pattern is on,on,off,off,on… per frame. Asserting cancel[1] in the middle of a frame has no effect until the next frame_start; at that frame_start msg_visible=0, then done=0010.
- Owner is req[3] with frames 0; req[0] asserts. Required: at the next frame_start msg_visible=0, then done=1000, then grant=0001. msg_id switches at the following frame_start.
- req[0] and req[1] are asserted in the same cycle in IDLE. Required: grant=0001 only. req[1], held through the end of message 0, is granted on the cycle after done=0001.
- Expiry frame (frames=1) coincides with cancel and a higher-priority req at one frame_start. Required: exactly one done pulse and a single DONE state.
- resetN is pulsed low in SHOW. Required: all outputs are 0 immediately (asynchronously); after release the FSM is in IDLE and no stale done pulse appears.

Source files
------------

// File: rtl/text_msg_if.sv
// Bundle of the requester-side and display-side signals of the on-screen message scheduler.
//   frame_start  : one-cycle pulse at the start of vertical blank
//   req/cancel   : per-requester level request / cancel
//   req_msg_id   : per-requester message id, slice [i*MSG_ID_W +: MSG_ID_W]
//   req_frames   : per-requester duration in frames (0 = persistent)
//   req_blink    : per-requester blink enable
//   grant/done   : one-hot single-cycle pulses back to requesters
//   msg_id, msg_visible : text layer select and enable
//   busy, owner  : scheduler status
// master: game-logic side; slave: scheduler side.
interface text_msg_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MSG_ID_W    = 3,
  parameter int unsigned FRAME_CNT_W = 8
) ();
  localparam int unsigned OWNER_W = $clog2(NUM_REQ);

  logic                            frame_start;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MSG_ID_W-1:0]     req_msg_id;
  logic [NUM_REQ*FRAME_CNT_W-1:0]  req_frames;
  logic [NUM_REQ-1:0]              req_blink;
  logic [NUM_REQ-1:0]              cancel;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              done;
  logic [MSG_ID_W-1:0]             msg_id;
  logic                            msg_visible;
  logic                            busy;
  logic [OWNER_W-1:0]              owner;

  modport master (
    output frame_start, req, req_msg_id, req_frames, req_blink, cancel,
    input  grant, done, msg_id, msg_visible, busy, owner
  );

  modport slave (
    input  frame_start, req, req_msg_id, req_frames, req_blink, cancel,
    output grant, done, msg_id, msg_visible, busy, owner
  );
endinterface

// File: rtl/text_msg_scheduler.sv
// Fixed-priority scheduler for the single on-screen message slot. Requester 0 has the highest
// priority. Displayed id and visibility only change on frame_start so the text layer never tears.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : text_msg_if slave modport (requests, cancel, grant/done, display outputs, status)
// All outputs are registered.
module text_msg_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MSG_ID_W     = 3,
  parameter int unsigned FRAME_CNT_W  = 8,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic     clk,
  input  logic     resetN,
  text_msg_if.slave bus
);
  localparam int unsigned OWNER_W = $clog2(NUM_REQ);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES) + 1;

  typedef enum logic [1:0] {StIdle, StArm, StShow, StDone} state_e;

  state_e                 state;
  logic [MSG_ID_W-1:0]    lat_id;
  logic [FRAME_CNT_W-1:0] lat_frames;
  logic                   lat_blink;
  logic [FRAME_CNT_W-1:0] frames_left;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   phase;

  // Lowest set request index and its per-requester fields.
  logic                   req_any;
  logic [OWNER_W-1:0]     req_idx;
  logic [MSG_ID_W-1:0]    sel_id;
  logic [FRAME_CNT_W-1:0] sel_frames;
  logic                   sel_blink;

  always_comb begin
    req_any    = 1'b0;
    req_idx    = '0;
    sel_id     = '0;
    sel_frames = '0;
    sel_blink  = 1'b0;
    // Walk downwards so the lowest set index wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        req_any    = 1'b1;
        req_idx    = OWNER_W'(i);
        sel_id     = bus.req_msg_id[i*MSG_ID_W +: MSG_ID_W];
        sel_frames = bus.req_frames[i*FRAME_CNT_W +: FRAME_CNT_W];
        sel_blink  = bus.req_blink[i];
      end
    end
  end

  logic preempt;
  logic cancel_own;
  logic expire;
  logic blink_wrap;

  always_comb begin
    preempt = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req[k] && (k < int'(bus.owner))) preempt = 1'b1;
    end
    cancel_own = bus.cancel[bus.owner];
    // frames_left is never decremented at 1, so it cannot wrap.
    expire     = (lat_frames != '0) && (frames_left == FRAME_CNT_W'(1));
    blink_wrap = (blink_cnt == BLINK_W'(BLINK_FRAMES - 1));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= StIdle;
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.msg_id      <= '0;
      bus.msg_visible <= 1'b0;
      bus.busy        <= 1'b0;
      bus.owner       <= '0;
      lat_id          <= '0;
      lat_frames      <= '0;
      lat_blink       <= 1'b0;
      frames_left     <= '0;
      blink_cnt       <= '0;
      phase           <= 1'b0;
    end else begin
      bus.grant <= '0;
      bus.done  <= '0;
      case (state)
        StIdle: begin
          if (req_any) begin
            bus.grant  <= NUM_REQ'(1) << req_idx;
            bus.owner  <= req_idx;
            bus.busy   <= 1'b1;
            lat_id     <= sel_id;
            lat_frames <= sel_frames;
            lat_blink  <= sel_blink;
            state      <= StArm;
          end
        end
        StArm: begin
          if (bus.frame_start) begin
            bus.msg_id      <= lat_id;
            bus.msg_visible <= 1'b1;
            frames_left     <= lat_frames;
            blink_cnt       <= '0;
            phase           <= 1'b1;
            state           <= StShow;
          end
        end
        StShow: begin
          if (bus.frame_start) begin
            if (cancel_own || preempt || expire) begin
              bus.msg_visible <= 1'b0;
              state           <= StDone;
            end else begin
              if (lat_frames != '0) frames_left <= frames_left - FRAME_CNT_W'(1);
              if (lat_blink) begin
                if (blink_wrap) begin
                  blink_cnt       <= '0;
                  phase           <= ~phase;
                  bus.msg_visible <= ~phase;
                end else begin
                  blink_cnt       <= blink_cnt + BLINK_W'(1);
                  bus.msg_visible <= phase;
                end
              end
            end
          end
        end
        StDone: begin
          bus.done <= NUM_REQ'(1) << bus.owner;
          bus.busy <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_text_msg_scheduler.sv
module tb_text_msg_scheduler;
  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned MSG_ID_W    = 3;
  localparam int unsigned FRAME_CNT_W = 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  text_msg_if #(.NUM_REQ(NUM_REQ), .MSG_ID_W(MSG_ID_W), .FRAME_CNT_W(FRAME_CNT_W)) bus ();

  text_msg_scheduler #(
    .NUM_REQ(NUM_REQ), .MSG_ID_W(MSG_ID_W), .FRAME_CNT_W(FRAME_CNT_W), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [2:0] id, input logic [7:0] frames,
                         input logic blink);
    bus.req_msg_id[i*MSG_ID_W +: MSG_ID_W]    = id;
    bus.req_frames[i*FRAME_CNT_W +: FRAME_CNT_W] = frames;
    bus.req_blink[i] = blink;
    bus.req[i] = 1'b1;
  endtask

  task automatic test_reset();
    bus.frame_start = 1'b0; bus.req = '0; bus.req_msg_id = '0; bus.req_frames = '0;
    bus.req_blink = '0; bus.cancel = '0;
    resetN = 1'b0;
    tick();
    vectors++; if (bus.grant !== 4'b0) begin miscompares++; $display("FAIL rst_grant got %b want 0000", bus.grant); end
    vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL rst_done got %b want 0000", bus.done); end
    vectors++; if (bus.msg_id !== 3'd0) begin miscompares++; $display("FAIL rst_msg_id got %0d want 0", bus.msg_id); end
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL rst_visible got %b want 0", bus.msg_visible); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    vectors++; if (bus.owner !== 2'd0) begin miscompares++; $display("FAIL rst_owner got %0d want 0", bus.owner); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_timed();
    set_req(2, 3'd5, 8'd3, 1'b0);
    tick();
    vectors++; if (bus.grant !== 4'b0100) begin miscompares++; $display("FAIL timed_grant got %b want 0100", bus.grant); end
    vectors++; if (bus.owner !== 2'd2) begin miscompares++; $display("FAIL timed_owner got %0d want 2", bus.owner); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL timed_busy got %b want 1", bus.busy); end
    bus.req[2] = 1'b0;
    tick();
    vectors++; if (bus.grant !== 4'b0) begin miscompares++; $display("FAIL timed_grant_pulse got %b want 0000", bus.grant); end
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL timed_arm_vis got %b want 0", bus.msg_visible); end
    tick();
    frame();
    vectors++; if (bus.msg_id !== 3'd5) begin miscompares++; $display("FAIL timed_id got %0d want 5", bus.msg_id); end
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL timed_vis0 got %b want 1", bus.msg_visible); end
    tick(); tick();
    frame();
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL timed_vis1 got %b want 1", bus.msg_visible); end
    tick();
    frame();
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL timed_vis2 got %b want 1", bus.msg_visible); end
    vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL timed_early_done got %b want 0000", bus.done); end
    tick();
    frame();
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL timed_vis3 got %b want 0", bus.msg_visible); end
    tick();
    vectors++; if (bus.done !== 4'b0100) begin miscompares++; $display("FAIL timed_done got %b want 0100", bus.done); end
    vectors++; if (bus.msg_id !== 3'd5) begin miscompares++; $display("FAIL timed_id_held got %0d want 5", bus.msg_id); end
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL timed_busy_end got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL timed_done_pulse got %b want 0000", bus.done); end
  endtask

  task automatic test_blink_cancel();
    logic [5:0] pat;
    pat = 6'b110011;  // per frame_start, first frame in the MSB
    set_req(1, 3'd2, 8'd0, 1'b1);
    tick();
    vectors++; if (bus.grant !== 4'b0010) begin miscompares++; $display("FAIL blink_grant got %b want 0010", bus.grant); end
    bus.req[1] = 1'b0;
    tick();
    for (int f = 0; f < 5; f++) begin
      frame();
      vectors++; if (bus.msg_visible !== pat[5-f]) begin miscompares++; $display("FAIL blink_vis%0d got %b want %b", f, bus.msg_visible, pat[5-f]); end
      tick();
    end
    bus.cancel[1] = 1'b1;
    tick();
    bus.cancel[1] = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL blink_cancel_unlatched_busy got %b want 1", bus.busy); end
    frame();
    vectors++; if (bus.msg_visible !== pat[0]) begin miscompares++; $display("FAIL blink_vis5 got %b want %b", bus.msg_visible, pat[0]); end
    vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL blink_no_done got %b want 0000", bus.done); end
    tick();
    bus.cancel[1] = 1'b1;
    tick();
    frame();
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL blink_cancel_vis got %b want 0", bus.msg_visible); end
    bus.cancel[1] = 1'b0;
    tick();
    vectors++; if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL blink_done got %b want 0010", bus.done); end
    tick();
  endtask

  task automatic test_preempt();
    set_req(3, 3'd6, 8'd0, 1'b0);
    tick();
    vectors++; if (bus.grant !== 4'b1000) begin miscompares++; $display("FAIL pre_grant3 got %b want 1000", bus.grant); end
    bus.req[3] = 1'b0;
    tick();
    frame();
    vectors++; if (bus.msg_id !== 3'd6) begin miscompares++; $display("FAIL pre_id6 got %0d want 6", bus.msg_id); end
    set_req(0, 3'd1, 8'd2, 1'b0);
    tick();
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL pre_hold_vis got %b want 1", bus.msg_visible); end
    frame();
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL pre_vis got %b want 0", bus.msg_visible); end
    tick();
    vectors++; if (bus.done !== 4'b1000) begin miscompares++; $display("FAIL pre_done got %b want 1000", bus.done); end
    tick();
    vectors++; if (bus.grant !== 4'b0001) begin miscompares++; $display("FAIL pre_grant0 got %b want 0001", bus.grant); end
    vectors++; if (bus.owner !== 2'd0) begin miscompares++; $display("FAIL pre_owner got %0d want 0", bus.owner); end
    bus.req[0] = 1'b0;
    tick();
    vectors++; if (bus.msg_id !== 3'd6) begin miscompares++; $display("FAIL pre_id_arm got %0d want 6", bus.msg_id); end
    frame();
    vectors++; if (bus.msg_id !== 3'd1) begin miscompares++; $display("FAIL pre_id1 got %0d want 1", bus.msg_id); end
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL pre_vis1 got %b want 1", bus.msg_visible); end
    frame();
    frame();
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL pre_expire got %b want 0", bus.msg_visible); end
    tick();
    vectors++; if (bus.done !== 4'b0001) begin miscompares++; $display("FAIL pre_done0 got %b want 0001", bus.done); end
    tick();
  endtask

  task automatic test_same_cycle();
    set_req(0, 3'd3, 8'd1, 1'b0);
    set_req(1, 3'd4, 8'd1, 1'b0);
    tick();
    vectors++; if (bus.grant !== 4'b0001) begin miscompares++; $display("FAIL same_grant got %b want 0001", bus.grant); end
    bus.req[0] = 1'b0;
    tick();
    frame();
    vectors++; if (bus.msg_id !== 3'd3) begin miscompares++; $display("FAIL same_id got %0d want 3", bus.msg_id); end
    frame();
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL same_expire got %b want 0", bus.msg_visible); end
    tick();
    vectors++; if (bus.done !== 4'b0001) begin miscompares++; $display("FAIL same_done got %b want 0001", bus.done); end
    vectors++; if (bus.grant !== 4'b0) begin miscompares++; $display("FAIL same_no_grant got %b want 0000", bus.grant); end
    tick();
    vectors++; if (bus.grant !== 4'b0010) begin miscompares++; $display("FAIL same_grant1 got %b want 0010", bus.grant); end
    bus.req[1] = 1'b0;
    tick();
    frame();
    vectors++; if (bus.msg_id !== 3'd4) begin miscompares++; $display("FAIL same_id4 got %0d want 4", bus.msg_id); end
    frame();
    tick();
    vectors++; if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL same_done1 got %b want 0010", bus.done); end
    tick();
  endtask

  task automatic test_coincide();
    set_req(2, 3'd7, 8'd1, 1'b0);
    tick();
    bus.req[2] = 1'b0;
    tick();
    frame();
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL coin_vis got %b want 1", bus.msg_visible); end
    bus.cancel[2] = 1'b1;
    set_req(1, 3'd2, 8'd1, 1'b0);
    tick();
    frame();
    bus.cancel[2] = 1'b0;
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL coin_vis_off got %b want 0", bus.msg_visible); end
    tick();
    vectors++; if (bus.done !== 4'b0100) begin miscompares++; $display("FAIL coin_done got %b want 0100", bus.done); end
    tick();
    vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL coin_single_done got %b want 0000", bus.done); end
    vectors++; if (bus.grant !== 4'b0010) begin miscompares++; $display("FAIL coin_grant got %b want 0010", bus.grant); end
    bus.req[1] = 1'b0;
    tick();
    frame();
    frame();
    tick();
    vectors++; if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL coin_done1 got %b want 0010", bus.done); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 3'd4, 8'd0, 1'b0);
    tick();
    bus.req[1] = 1'b0;
    tick();
    frame();
    vectors++; if (bus.msg_visible !== 1'b1) begin miscompares++; $display("FAIL rmid_vis got %b want 1", bus.msg_visible); end
    #2;
    resetN = 1'b0;
    #1;
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL rmid_async_vis got %b want 0", bus.msg_visible); end
    vectors++; if (bus.msg_id !== 3'd0) begin miscompares++; $display("FAIL rmid_async_id got %0d want 0", bus.msg_id); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_async_busy got %b want 0", bus.busy); end
    vectors++; if (bus.owner !== 2'd0) begin miscompares++; $display("FAIL rmid_async_owner got %0d want 0", bus.owner); end
    tick();
    resetN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (bus.done !== 4'b0) begin miscompares++; $display("FAIL rmid_stale_done%0d got %b want 0000", c, bus.done); end
    end
    frame();
    vectors++; if (bus.msg_visible !== 1'b0) begin miscompares++; $display("FAIL rmid_idle_vis got %b want 0", bus.msg_visible); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_idle_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_timed();
    test_blink_cancel();
    test_preempt();
    test_same_cycle();
    test_coincide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
